// File: rtl/ex_mac_pkg.sv
// ex_mac_pkg: shared definitions for the EX-stage multiply/accumulate unit.
//   - MAC op encodings (the 2-bit op field from ID/EX)
//   - FSM state constants
//   - ACC_REG: destination register number that selects the 64-bit accumulator
//   - MAC_WIDTH / ITER: default operand width and shift-add iteration count
package ex_mac_pkg;

  localparam int MAC_WIDTH = 32;
  localparam int ITER      = MAC_WIDTH;

  typedef logic [1:0] mac_op_t;

  localparam mac_op_t MAC_OP_MUL  = 2'b00;  // signed a*b
  localparam mac_op_t MAC_OP_MAC  = 2'b01;  // acc + a*b
  localparam mac_op_t MAC_OP_MSUB = 2'b10;  // acc - a*b
  localparam mac_op_t MAC_OP_MULU = 2'b11;  // unsigned a*b

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [4:0] ACC_REG = 5'd31;

endpackage

// File: rtl/ex_mac_unit_if.sv
// ex_mac_unit_if: request/response bundle between the ID/EX register and the
// MAC unit.
//   master (ID/EX side) drives: start, op, a, b, acc_in, rd, flush
//   master receives:            stall, done, result, rd_out
//   slave is the MAC unit, with the directions reversed.
interface ex_mac_unit_if
  import ex_mac_pkg::*;
#(
  parameter int WIDTH = ITER
);
  logic                 start;
  mac_op_t              op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   acc_in;
  logic [4:0]           rd;
  logic                 flush;
  logic                 stall;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic [4:0]           rd_out;

  modport master (
    output start, op, a, b, acc_in, rd, flush,
    input  stall, done, result, rd_out
  );

  modport slave (
    input  start, op, a, b, acc_in, rd, flush,
    output stall, done, result, rd_out
  );
endinterface

// File: rtl/mac_shift_add_core.sv
// mac_shift_add_core: radix-2 shift-add multiplier datapath on unsigned
// magnitudes.
// Ports:
//   clk, res    clock, asynchronous active-low reset (clears all registers)
//   load_i      capture mcand_i/mplier_i and clear the partial product
//   step_i      one iteration: conditional add, then shift both operands
//   mcand_i     multiplicand magnitude
//   mplier_i    multiplier magnitude
//   partial_o   running unsigned partial product
//   zero_o      no multiplier bits remain to be consumed
module mac_shift_add_core #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     mplier_i,
  output logic [2*WIDTH-1:0]   partial_o,
  output logic                 zero_o
);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] partial_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
    end else if (load_i) begin
      mcand_q   <= {{WIDTH{1'b0}}, mcand_i};
      mplier_q  <= mplier_i;
      partial_q <= '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        partial_q <= partial_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  assign partial_o = partial_q;
  assign zero_o    = (mplier_q == '0);

endmodule

// File: rtl/ex_mac_unit.sv
// ex_mac_unit: multi-cycle multiply/accumulate unit in the EX stage.
// Ports:
//   clk   system clock, rising edge
//   res   asynchronous active-low reset
//   bus   ex_mac_unit_if.slave: start/op/a/b/acc_in/rd/flush in,
//         stall/done/result/rd_out out
// Operation: IDLE latches operand magnitudes and sign, BUSY runs WIDTH
// shift-add iterations, FIX applies sign and accumulate, DONE strobes done.
// Build option: define MAC_EARLY_EXIT_EN to leave BUSY as soon as no
// multiplier bits remain (results unchanged, latency data-dependent).
module ex_mac_unit
  import ex_mac_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic             clk,
  input  logic             res,
  ex_mac_unit_if.slave     bus
);

  localparam int CW = $clog2(WIDTH);

`ifdef MAC_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  logic [1:0]          state_q, state_d;
  mac_op_t             op_q;
  logic [4:0]          rd_q;
  logic [4:0]          rd_out_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [2*WIDTH-1:0]  result_q;
  logic                neg_q;
  logic [CW-1:0]       count_q;

  logic                is_signed;
  logic                load;
  logic                step;
  logic                core_zero;
  logic [WIDTH-1:0]    mag_a;
  logic [WIDTH-1:0]    mag_b;
  logic [2*WIDTH-1:0]  partial;

  // The most-negative value negates to itself, which read as unsigned is
  // exactly its magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    magnitude = (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // Sign fix and accumulate, all modulo 2^(2*WIDTH).
  function automatic logic [2*WIDTH-1:0] fix_result(input mac_op_t op_sel,
                                                    input logic neg,
                                                    input logic [2*WIDTH-1:0] prod,
                                                    input logic [2*WIDTH-1:0] acc);
    logic signed [2*WIDTH-1:0] p;
    logic signed [2*WIDTH-1:0] s_acc;
    p     = neg ? -$signed(prod) : $signed(prod);
    s_acc = $signed(acc);
    case (op_sel)
      MAC_OP_MAC:  fix_result = s_acc + p;
      MAC_OP_MSUB: fix_result = s_acc - p;
      default:     fix_result = p;
    endcase
  endfunction

  assign is_signed = (bus.op != MAC_OP_MULU);
  assign mag_a     = magnitude(bus.a, is_signed);
  assign mag_b     = magnitude(bus.b, is_signed);

  // flush blocks both a new load and any further iteration
  assign load = (state_q == ST_IDLE) && bus.start && !bus.flush;
  assign step = (state_q == ST_BUSY) && !bus.flush;

  mac_shift_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .res       (res),
    .load_i    (load),
    .step_i    (step),
    .mcand_i   (mag_a),
    .mplier_i  (mag_b),
    .partial_o (partial),
    .zero_o    (core_zero)
  );

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) state_d = ST_BUSY;
        ST_BUSY: if (count_q == '0 || (EarlyExit && core_zero)) state_d = ST_FIX;
        ST_FIX:  state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= ST_IDLE;
      op_q     <= MAC_OP_MUL;
      rd_q     <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        op_q    <= bus.op;
        rd_q    <= bus.rd;
        acc_q   <= bus.acc_in;
        neg_q   <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        count_q <= CW'(WIDTH - 1);
      end else if (step && count_q != '0) begin
        count_q <= count_q - CW'(1);
      end
      // result/rd_out change only on a completed FIX; a flush leaves them intact
      if (state_q == ST_FIX && !bus.flush) begin
        result_q <= fix_result(op_q, neg_q, partial, acc_q);
        rd_out_q <= rd_q;
      end
    end
  end

  // stall drops in DONE so the pipeline advances with the valid result
  assign bus.stall  = ((state_q == ST_IDLE) && bus.start) ||
                      (state_q == ST_BUSY) || (state_q == ST_FIX);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_mac_unit.sv
// tb_ex_mac_unit: directed and randomized checks of ex_mac_unit against a
// behavioural reference (64-bit integer arithmetic and a latency rule).
module tb_ex_mac_unit;
  import ex_mac_pkg::*;

  logic clk;
  logic res;
  int   errors;
  int   checks;
  logic [63:0] last_exp;
  logic [4:0]  last_rd;

  ex_mac_unit_if #(.WIDTH(32)) bus ();

  ex_mac_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact product from integer arithmetic, then accumulate mod 2^64.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] av,
                                             input logic [31:0] bv, input logic [63:0] acc);
    longint sa, sb, p;
    if (o == MAC_OP_MULU) begin
      sa = longint'({32'b0, av});
      sb = longint'({32'b0, bv});
    end else begin
      sa = $signed(av);
      sb = $signed(bv);
    end
    p = sa * sb;
    case (o)
      MAC_OP_MAC:  return acc + p;
      MAC_OP_MSUB: return acc - p;
      default:     return p;
    endcase
  endfunction

  // Cycles from the start edge to the cycle where done is high.
  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] bv);
`ifdef MAC_EARLY_EXIT_EN
    logic [31:0] m;
    int k;
    m = (o != MAC_OP_MULU && bv[31]) ? -bv : bv;
    k = 0;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    return (k + 2 > 33) ? 33 : k + 2;
`else
    return 33;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] acc, input logic [4:0] r,
                        input logic [63:0] exp, input int exp_lat, input bit poke);
    int n;
    int extra;
    bit stall_low;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv; bus.acc_in = acc; bus.rd = r;
    #1;
    check({tag, ".stall_req"}, 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    // scramble inputs: the unit must work from its latched copies
    bus.start = 1'b0; bus.op = ~o; bus.rd = ~r;
    bus.a = $urandom; bus.b = $urandom; bus.acc_in = {$urandom, $urandom};
    n = 0;
    stall_low = 1'b0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.stall !== 1'b1) stall_low = 1'b1;
      if (poke && n == 2) bus.start = 1'b1;
      if (poke && n == 3) bus.start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check({tag, ".latency"}, 64'(n), 64'(exp_lat));
    check({tag, ".stall_busy"}, 64'(stall_low), 64'd0);
    check({tag, ".result"}, bus.result, exp);
    check({tag, ".rd_out"}, 64'(bus.rd_out), 64'(r));
    check({tag, ".stall_done"}, 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    check({tag, ".done_1cyc"}, 64'(bus.done), 64'd0);
    if (poke) begin
      extra = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (bus.done === 1'b1) extra++;
      end
      check({tag, ".extra_done"}, 64'(extra), 64'd0);
      check({tag, ".result_kept"}, bus.result, exp);
    end
    last_exp = exp;
    last_rd  = r;
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] av, bv;
    logic [63:0] acc;
    logic [4:0]  r;
    int          n;
    int          lat_b0, lat_b1;

    errors = 0; checks = 0;
    last_exp = '0; last_rd = '0;
    res = 1'b0;
    bus.start = 1'b0; bus.op = MAC_OP_MUL; bus.a = '0; bus.b = '0;
    bus.acc_in = '0; bus.rd = '0; bus.flush = 1'b0;
`ifdef MAC_EARLY_EXIT_EN
    lat_b0 = 2; lat_b1 = 3;
`else
    lat_b0 = 33; lat_b1 = 33;
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.result", bus.result, 64'd0);
    check("rst.rd_out", 64'(bus.rd_out), 64'd0);
    check("rst.stall", 64'(bus.stall), 64'd0);
    @(negedge clk); res = 1'b1;

    // directed cases
    run_op("mul_7_m3", MAC_OP_MUL, 32'd7, 32'hFFFF_FFFD, 64'd0, 5'd5,
           64'hFFFF_FFFF_FFFF_FFEB, ref_latency(MAC_OP_MUL, 32'hFFFF_FFFD), 1'b0);
    run_op("mac_max", MAC_OP_MAC, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'd100, ACC_REG,
           64'h3FFF_FFFF_0000_0065, ref_latency(MAC_OP_MAC, 32'h7FFF_FFFF), 1'b0);
    run_op("mulu_max", MAC_OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 5'd3,
           64'hFFFF_FFFE_0000_0001, 33, 1'b0);
    run_op("mul_minneg", MAC_OP_MUL, 32'h8000_0000, 32'h8000_0000, 64'd0, 5'd9,
           64'h4000_0000_0000_0000, 33, 1'b0);
    run_op("msub_poke", MAC_OP_MSUB, 32'd5, 32'd5, 64'd0, 5'd12,
           64'hFFFF_FFFF_FFFF_FFE7, ref_latency(MAC_OP_MSUB, 32'd5), 1'b1);
    run_op("mac_b0", MAC_OP_MAC, 32'h1234_5678, 32'd0, 64'h0000_00AB_CDEF_0000, 5'd1,
           64'h0000_00AB_CDEF_0000, lat_b0, 1'b0);
    run_op("mul_b1", MAC_OP_MUL, 32'hDEAD_BEEF, 32'd1, 64'd0, 5'd2,
           64'hFFFF_FFFF_DEAD_BEEF, lat_b1, 1'b0);
    run_op("mulu_a0", MAC_OP_MULU, 32'd0, 32'hFFFF_0000, 64'd0, 5'd4,
           64'd0, 33, 1'b0);

    // randomized cases against the reference model
    for (int i = 0; i < 10; i++) begin
      o   = 2'($urandom_range(0, 3));
      av  = $urandom;
      bv  = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 255));
      acc = {$urandom, $urandom};
      r   = 5'($urandom_range(0, 31));
      run_op($sformatf("rand%0d", i), o, av, bv, acc, r,
             ref_result(o, av, bv, acc), ref_latency(o, bv), 1'b0);
    end

    // flush in the 10th BUSY cycle
    @(negedge clk);
    bus.start = 1'b1; bus.op = MAC_OP_MULU; bus.a = 32'd11; bus.b = 32'hF000_0001; bus.rd = 5'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush.stall", 64'(bus.stall), 64'd0);
    check("flush.done", 64'(bus.done), 64'd0);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) n++;
    end
    check("flush.no_done", 64'(n), 64'd0);
    check("flush.result", bus.result, last_exp);
    check("flush.rd_out", 64'(bus.rd_out), 64'(last_rd));

    // asynchronous reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.op = MAC_OP_MAC; bus.a = 32'd77; bus.b = 32'h8000_1234;
    bus.acc_in = 64'd5; bus.rd = 5'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    res = 1'b0;
    #1;
    check("ares.result", bus.result, 64'd0);
    check("ares.done", 64'(bus.done), 64'd0);
    check("ares.rd_out", 64'(bus.rd_out), 64'd0);
    check("ares.stall", 64'(bus.stall), 64'd0);
    @(negedge clk); res = 1'b1;
    run_op("post_rst", MAC_OP_MULU, 32'd3, 32'h8000_0005, 64'd0, 5'd6,
           64'h0000_0001_8000_000F, 33, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mac_unit.md
Name: ex_mac_unit

Overview:
- Multi-cycle multiply/accumulate unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched rs1/rs2 data, the 64-bit accumulator, the destination register number and a MAC op code.
- Produces the 64-bit result that feeds the register file's 64-bit accumulator write path (write_data_acc); destination register 31 selects the accumulator.
- Holds the front of the pipeline with a stall while it iterates.

Parameters:
- WIDTH, 32, operand width; result width is 2*WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous active-low reset.
- start  in  1  op request from ID/EX; sampled only in IDLE.
- op  in  2  00 MUL signed, 01 MAC (acc + a*b), 10 MSUB (acc - a*b), 11 MULU unsigned.
- a  in  WIDTH  multiplicand (rs1 data).
- b  in  WIDTH  multiplier (rs2 data).
- acc_in  in  2*WIDTH  accumulator value for MAC/MSUB.
- rd  in  5  destination; 31 = accumulator.
- flush  in  1  synchronous abort.
- stall  out  1  holds IF/ID and ID/EX.
- done  out  1  one-cycle result-valid strobe.
- result  out  2*WIDTH  product or accumulated value.
- rd_out  out  5  destination accompanying result.

Behaviour:
- Clock and reset: single clock clk; res is asynchronous, active-low. res=0 forces state=IDLE and done=0, result=0, rd_out=0, and clears all internal registers immediately, including mid-operation. No partial result is ever emitted.
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - On start=1 at an edge, latch op, rd, acc_in and the operand magnitudes (|a|, |b| for signed ops; raw values for MULU).
  - Latch neg = a[31]^b[31] for signed ops; neg=0 for MULU.
  - Clear the 64-bit partial product, load count=WIDTH-1, go to BUSY.
  - start while not in IDLE is ignored. There is no queueing; the stall output prevents a new request.
- BUSY:
  - Radix-2 shift-add, one multiplier bit per cycle: if mplier[0]=1, add the shifted multiplicand to the partial product. Then shift the multiplicand left and the multiplier right.
  - At count==0 go to FIX; otherwise decrement count.
  - WIDTH iterations total.
- FIX:
  - p = neg ? -partial : partial.
  - MUL/MULU: result<=p. MAC: result<=acc_in+p. MSUB: result<=acc_in-p.
  - All arithmetic is modulo 2^64; overflow wraps silently.
  - rd_out<=rd. Go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE. result and rd_out hold their values until the next FIX.
- Latency: start sampled at edge E0; BUSY covers E1..E32; FIX at E33; done is high in the cycle after E33 (33 cycles).
- stall = (IDLE & start) | BUSY | FIX. stall is low in DONE so the pipeline advances in the same cycle the result is valid.
- flush=1 at any edge returns the unit to IDLE with no done; result and rd_out keep their previous values. flush has priority over start and iteration.
- Edge cases:
  - Most-negative operand 0x80000000: its magnitude is 0x80000000 treated as unsigned; the result is exact.
  - a=0 or b=0 gives result 0 (or acc_in for MAC/MSUB).

Optional Feature:
- Macro MAC_EARLY_EXIT_EN.
- When defined: in BUSY, if the remaining multiplier bits are all zero, go to FIX at that edge without further iterations.
  - b=0: done is high after E2.
  - b=1: done is high after E3.
  - Results are identical to the full-length run.
- When undefined: latency is always 33 cycles regardless of data.

Decomposition:
- Package ex_mac_pkg: op encodings (MAC_OP_MUL, MAC_OP_MAC, MAC_OP_MSUB, MAC_OP_MULU), state enum, ACC_REG=5'd31, ITER=WIDTH.
- One sub-module, mac_shift_add_core: the partial-product/multiplicand/multiplier registers and per-cycle add-shift, with a load/step/zero interface.
- The FSM, sign fix, accumulate and stall logic stay in ex_mac_unit.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), rd=5 -> done after 33 cycles; result=0xFFFFFFFFFFFFFFEB; rd_out=5; stall high for 33 cycles.
- MAC acc_in=100, a=b=0x7FFFFFFF, rd=31 -> result=0x3FFFFFFF00000065, rd_out=31.
- MULU a=b=0xFFFFFFFF -> result=0xFFFFFFFE00000001. Signed MUL a=0x80000000, b=0x80000000 -> 0x4000000000000000.
- MSUB acc_in=0, a=b=5 -> 0xFFFFFFFFFFFFFFE7. Pulse start again during BUSY -> ignored: exactly one done, and the result is unchanged by the second operands.
- flush at cycle 10 of BUSY -> no done, stall drops the next cycle, result keeps its prior value. res=0 at cycle 20 -> result=0, done=0 immediately; a new start after release runs a full 33 cycles.
- With MAC_EARLY_EXIT_EN: b=0 -> done after 2 cycles; b=1 -> done after 3 cycles. Without it: both take 33 cycles, with identical results.
